// File: rtl/my_serdes_rx.sv
// my_serdes_rx: receive-side deframer for the USRP2 SERDES link.
// Registers the incoming word/K-flag pair, acquires word lock from the comma
// pattern, strips commas, drops K-code errors and buffers data words in a
// small FIFO with a guarded dequeue interface.
// Optional statistics counters: define MY_SERDES_RX_STATS_EN.
module my_serdes_rx #(
  parameter int FIFOSIZE     = 4,
  parameter int CNTR_WIDTH   = 2,
  parameter int LOCK_COMMAS  = 4,
  parameter int ERR_LIMIT    = 3,
  parameter int LOSS_TIMEOUT = 70000
) (
  input  logic        dsp_clk,
  input  logic        dsp_rst,
  input  logic [15:0] ser_r,
  input  logic        ser_rklsb,
  input  logic        ser_rkmsb,
  output logic [15:0] rx_dat_o,
  output logic        rx_valid,
  input  logic        rx_deq,
  output logic        link_up,
  output logic        rx_overflow
`ifdef MY_SERDES_RX_STATS_EN
  ,
  output logic [31:0] rx_word_cnt,
  output logic [15:0] rx_err_cnt
`endif
);

  localparam logic [15:0] COMMA = 16'h3C3C;
  localparam int LCW = $clog2(LOCK_COMMAS + 1);
  localparam int ECW = $clog2(ERR_LIMIT + 1);
  localparam int LSW = $clog2(LOSS_TIMEOUT);
  localparam logic [LCW-1:0]        LOCK_LAST = LCW'(LOCK_COMMAS - 1);
  localparam logic [LCW-1:0]        LOCK_FULL = LCW'(LOCK_COMMAS);
  localparam logic [ECW-1:0]        ERR_LAST  = ECW'(ERR_LIMIT - 1);
  localparam logic [LSW-1:0]        LOSS_LAST = LSW'(LOSS_TIMEOUT - 2);
  localparam logic [CNTR_WIDTH:0]   FULL_CNT  = (CNTR_WIDTH + 1)'(FIFOSIZE);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_e;

  logic [15:0]         r_dat_q;
  logic                r_kl_q, r_km_q;
  logic                is_comma, is_data, is_kerr;
  state_e              state_q, state_d;
  logic [LCW-1:0]      comma_cnt_q, comma_cnt_d;
  logic [ECW-1:0]      err_cnt_q, err_cnt_d;
  logic [LSW-1:0]      loss_cnt_q, loss_cnt_d;
  logic                enq_req;
  logic [15:0]         mem_q [FIFOSIZE];
  logic [CNTR_WIDTH-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNTR_WIDTH:0] count_q, count_d;
  logic                full, do_enq, do_deq;
  logic                rx_overflow_q;

  // Input register: all classification works on this registered copy.
  always_ff @(posedge dsp_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (dsp_rst) begin
      r_dat_q <= '0;
      r_kl_q  <= 1'b0;
      r_km_q  <= 1'b0;
    end else begin
      r_dat_q <= ser_r;
      r_kl_q  <= ser_rklsb;
      r_km_q  <= ser_rkmsb;
    end
  end

  assign is_comma = r_kl_q & r_km_q & (r_dat_q == COMMA);
  assign is_data  = ~r_kl_q & ~r_km_q;
  assign is_kerr  = ~is_comma & ~is_data;

  // Lock FSM state and counter registers.
  always_ff @(posedge dsp_clk) begin
    if (dsp_rst) begin
      state_q     <= HUNT;
      comma_cnt_q <= '0;
      err_cnt_q   <= '0;
      loss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      comma_cnt_q <= comma_cnt_d;
      err_cnt_q   <= err_cnt_d;
      loss_cnt_q  <= loss_cnt_d;
    end
  end

  // Lock FSM next state; counters cannot wrap because reaching their limit
  // forces the exit that clears them.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    err_cnt_d   = err_cnt_q;
    loss_cnt_d  = loss_cnt_q;
    enq_req     = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (is_comma) begin
          comma_cnt_d = LCW'(1);
          state_d     = SYNC;
        end
      end
      SYNC: begin
        if (!is_comma) begin
          comma_cnt_d = '0;
          state_d     = HUNT;
        end else if (comma_cnt_q >= LOCK_LAST) begin
          comma_cnt_d = LOCK_FULL;
          state_d     = LOCKED;
        end else begin
          comma_cnt_d = comma_cnt_q + 1'b1;
        end
      end
      LOCKED: begin
        if (is_comma) begin
          err_cnt_d  = '0;
          loss_cnt_d = '0;
        end else begin
          // Data is still enqueued in the cycle a loss timeout drops lock.
          enq_req    = is_data;
          loss_cnt_d = loss_cnt_q + 1'b1;
          if (is_kerr) err_cnt_d = err_cnt_q + 1'b1;
          if ((is_kerr && (err_cnt_q >= ERR_LAST)) || (loss_cnt_q >= LOSS_LAST)) begin
            state_d     = HUNT;
            comma_cnt_d = '0;
            err_cnt_d   = '0;
            loss_cnt_d  = '0;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  assign link_up = (state_q == LOCKED);

  // FIFO control: a full FIFO still accepts a word when the head pops in
  // the same cycle.
  assign full   = (count_q == FULL_CNT);
  assign do_deq = rx_deq & (count_q != '0);
  assign do_enq = enq_req & (~full | rx_deq);

  // FIFO storage, written at the tail.
  always_ff @(posedge dsp_clk) begin
    // NOTE: the storage array has no reset; validity is tracked by count_q
    // and the output is gated to zero while the FIFO is empty.
    if (do_enq) mem_q[wr_ptr_q] <= r_dat_q;
  end

  // Occupancy next state.
  always_comb begin
    count_d = count_q;
    unique case ({do_enq, do_deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge dsp_clk) begin
    if (dsp_rst) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      rx_overflow_q <= 1'b0;
    end else begin
      if (do_enq) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_deq) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (enq_req && full && !rx_deq) rx_overflow_q <= 1'b1;
    end
  end

  assign rx_valid    = (count_q != '0);
  assign rx_dat_o    = rx_valid ? mem_q[rd_ptr_q] : 16'h0000;
  assign rx_overflow = rx_overflow_q;

`ifdef MY_SERDES_RX_STATS_EN
  logic [31:0] word_cnt_q;
  logic [15:0] err_stat_q;
  logic        kerr_in_locked;

  assign kerr_in_locked = (state_q == LOCKED) & is_kerr;

  // Saturating statistics counters.
  always_ff @(posedge dsp_clk) begin
    if (dsp_rst) begin
      word_cnt_q <= '0;
      err_stat_q <= '0;
    end else begin
      if (do_enq && (word_cnt_q != '1)) word_cnt_q <= word_cnt_q + 1'b1;
      if (kerr_in_locked && (err_stat_q != '1)) err_stat_q <= err_stat_q + 1'b1;
    end
  end

  assign rx_word_cnt = word_cnt_q;
  assign rx_err_cnt  = err_stat_q;
`endif

endmodule

// File: tb/tb_my_serdes_rx.sv
// Directed self-checking bench for my_serdes_rx. Inputs change 1 ns after
// each rising edge; outputs are sampled at that same point, away from the edge.
module tb_my_serdes_rx;

  logic        dsp_clk;
  logic        dsp_rst;
  logic [15:0] ser_r;
  logic        ser_rklsb;
  logic        ser_rkmsb;
  logic [15:0] rx_dat_o;
  logic        rx_valid;
  logic        rx_deq;
  logic        link_up;
  logic        rx_overflow;
`ifdef MY_SERDES_RX_STATS_EN
  logic [31:0] rx_word_cnt;
  logic [15:0] rx_err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  my_serdes_rx dut (
    .dsp_clk     (dsp_clk),
    .dsp_rst     (dsp_rst),
    .ser_r       (ser_r),
    .ser_rklsb   (ser_rklsb),
    .ser_rkmsb   (ser_rkmsb),
    .rx_dat_o    (rx_dat_o),
    .rx_valid    (rx_valid),
    .rx_deq      (rx_deq),
    .link_up     (link_up),
    .rx_overflow (rx_overflow)
`ifdef MY_SERDES_RX_STATS_EN
    ,
    .rx_word_cnt (rx_word_cnt),
    .rx_err_cnt  (rx_err_cnt)
`endif
  );

  initial dsp_clk = 1'b0;
  always #5 dsp_clk = ~dsp_clk;

  // Present one word for one clock edge, then return to the sample point.
  task automatic send(input logic [15:0] d, input logic kl, input logic km, input logic deq);
    ser_r = d; ser_rklsb = kl; ser_rkmsb = km; rx_deq = deq;
    @(posedge dsp_clk); #1;
    rx_deq = 1'b0;
  endtask

  task automatic comma(input logic deq);
    send(16'h3C3C, 1'b1, 1'b1, deq);
  endtask

  task automatic data(input logic [15:0] d);
    send(d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    dsp_rst = 1'b1;
    send(16'h0000, 1'b0, 1'b0, 1'b0);
    send(16'h0000, 1'b0, 1'b0, 1'b0);
    dsp_rst = 1'b0;
  endtask

  // Five commas: the fourth is classified on the fifth edge.
  task automatic lock_link();
    repeat (5) comma(1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL reset_link_up got %b exp 0", link_up); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b exp 0", rx_valid); end
    checks++; if (rx_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", rx_overflow); end
    checks++; if (rx_dat_o !== 16'h0000) begin errors++; $display("FAIL reset_rx_dat got %h exp 0000", rx_dat_o); end
`ifdef MY_SERDES_RX_STATS_EN
    checks++; if (rx_word_cnt !== 32'd0) begin errors++; $display("FAIL reset_word_cnt got %0d exp 0", rx_word_cnt); end
    checks++; if (rx_err_cnt !== 16'd0) begin errors++; $display("FAIL reset_err_cnt got %0d exp 0", rx_err_cnt); end
`endif
  endtask

  task automatic test_lock();
    do_reset();
    repeat (4) comma(1'b0);
    checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL lock_early got %b exp 0", link_up); end
    data(16'h1234);
    checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL lock_up got %b exp 1", link_up); end
    data(16'hABCD);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL lock_valid got %b exp 1", rx_valid); end
    checks++; if (rx_dat_o !== 16'h1234) begin errors++; $display("FAIL lock_head1 got %h exp 1234", rx_dat_o); end
    comma(1'b0);
    comma(1'b1);
    checks++; if (rx_dat_o !== 16'hABCD) begin errors++; $display("FAIL lock_head2 got %h exp abcd", rx_dat_o); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL lock_valid2 got %b exp 1", rx_valid); end
    comma(1'b1);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL lock_drained got %b exp 0", rx_valid); end
`ifdef MY_SERDES_RX_STATS_EN
    checks++; if (rx_word_cnt !== 32'd2) begin errors++; $display("FAIL lock_word_cnt got %0d exp 2", rx_word_cnt); end
`endif
  endtask

  task automatic test_broken_sync();
    do_reset();
    comma(1'b0); comma(1'b0); data(16'h5555); comma(1'b0);
    comma(1'b0); comma(1'b0); comma(1'b0);
    // Classified so far: c c d c c c -> only three commas since the break.
    checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL sync_no_lock got %b exp 0", link_up); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL sync_no_enq got %b exp 0", rx_valid); end
    comma(1'b0);
    checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL sync_relock got %b exp 1", link_up); end
  endtask

  task automatic test_overflow();
    do_reset();
    lock_link();
    for (int i = 1; i <= 6; i++) data(16'(i));
    comma(1'b0);
    checks++; if (rx_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", rx_overflow); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (rx_dat_o !== 16'(i)) begin errors++; $display("FAIL ovf_head got %h exp %h", rx_dat_o, 16'(i)); end
      comma(1'b1);
    end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b exp 0", rx_valid); end

    // Full FIFO with a pop in the same cycle accepts the fifth word.
    do_reset();
    lock_link();
    for (int i = 1; i <= 5; i++) data(16'(i));
    comma(1'b1);
    checks++; if (rx_overflow !== 1'b0) begin errors++; $display("FAIL ovf_deq_clear got %b exp 0", rx_overflow); end
    for (int i = 2; i <= 5; i++) begin
      checks++; if (rx_dat_o !== 16'(i)) begin errors++; $display("FAIL ovf_deq_head got %h exp %h", rx_dat_o, 16'(i)); end
      comma(1'b1);
    end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovf_deq_drained got %b exp 0", rx_valid); end
  endtask

  task automatic test_kerr();
    do_reset();
    lock_link();
    send(16'h1111, 1'b1, 1'b0, 1'b0);
    send(16'h2222, 1'b1, 1'b0, 1'b0);
    send(16'h3333, 1'b1, 1'b0, 1'b0);
    checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL kerr_two got %b exp 1", link_up); end
    comma(1'b0);
    checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL kerr_three got %b exp 0", link_up); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL kerr_no_enq got %b exp 0", rx_valid); end
`ifdef MY_SERDES_RX_STATS_EN
    checks++; if (rx_err_cnt !== 16'd3) begin errors++; $display("FAIL kerr_err_cnt got %0d exp 3", rx_err_cnt); end
`endif

    // A comma between the second and third error resets the count.
    do_reset();
    lock_link();
    send(16'h1111, 1'b1, 1'b0, 1'b0);
    send(16'h2222, 1'b1, 1'b0, 1'b0);
    comma(1'b0);
    send(16'h3333, 1'b1, 1'b0, 1'b0);
    comma(1'b0);
    checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL kerr_comma_hold got %b exp 1", link_up); end

    // High-byte flag only and both flags on a non-comma value are K-errors.
    do_reset();
    lock_link();
    send(16'h1234, 1'b1, 1'b1, 1'b0);
    send(16'h4444, 1'b0, 1'b1, 1'b0);
    send(16'h5555, 1'b1, 1'b0, 1'b0);
    comma(1'b0);
    checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL kerr_mixed got %b exp 0", link_up); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL kerr_mixed_enq got %b exp 0", rx_valid); end
  endtask

  task automatic test_loss_timeout();
    do_reset();
    lock_link();
    // Word k is sent on edge L+k and classified on edge L+k+1, where L is
    // the edge that classifies the last comma. Popping every cycle keeps
    // only the newest word queued.
    for (int k = 0; k <= 69997; k++) send(16'(k), 1'b0, 1'b0, 1'b1);
    checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL loss_early got %b exp 1", link_up); end
    send(16'(69998), 1'b0, 1'b0, 1'b1);
    checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL loss_69998 got %b exp 1", link_up); end
    send(16'h0000, 1'b0, 1'b0, 1'b1);
    checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL loss_69999 got %b exp 0", link_up); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL loss_valid got %b exp 1", rx_valid); end
    checks++; if (rx_dat_o !== 16'h116E) begin errors++; $display("FAIL loss_last_word got %h exp 116e", rx_dat_o); end
    data(16'h7777);
    checks++; if (rx_dat_o !== 16'h116E) begin errors++; $display("FAIL loss_hunt_no_enq got %h exp 116e", rx_dat_o); end
    comma(1'b1);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL loss_drained got %b exp 0", rx_valid); end
    checks++; if (rx_overflow !== 1'b0) begin errors++; $display("FAIL loss_no_ovf got %b exp 0", rx_overflow); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    lock_link();
    data(16'h00A1); data(16'h00A2); data(16'h00A3);
    comma(1'b0);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b exp 1", rx_valid); end
    dsp_rst = 1'b1;
    comma(1'b0);
    dsp_rst = 1'b0;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", rx_valid); end
    checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL mid_link got %b exp 0", link_up); end
    checks++; if (rx_overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf got %b exp 0", rx_overflow); end
`ifdef MY_SERDES_RX_STATS_EN
    checks++; if (rx_word_cnt !== 32'd0) begin errors++; $display("FAIL mid_word_cnt got %0d exp 0", rx_word_cnt); end
    checks++; if (rx_err_cnt !== 16'd0) begin errors++; $display("FAIL mid_err_cnt got %0d exp 0", rx_err_cnt); end
`endif
    // The comma driven during reset must not survive in the input register.
    repeat (4) comma(1'b0);
    checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL mid_inreg_cleared got %b exp 0", link_up); end
    comma(1'b0);
    checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL mid_relock got %b exp 1", link_up); end
    data(16'h0055);
    comma(1'b0);
    checks++; if (rx_dat_o !== 16'h0055) begin errors++; $display("FAIL mid_fresh_head got %h exp 0055", rx_dat_o); end
  endtask

  initial begin
    dsp_rst = 1'b1; ser_r = '0; ser_rklsb = 1'b0; ser_rkmsb = 1'b0; rx_deq = 1'b0;
    test_reset();
    test_lock();
    test_broken_sync();
    test_overflow();
    test_kerr();
    test_loss_timeout();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
